// File: rtl/calc_pkg.sv
// Shared ASCII token constants and FSM state encoding for the calculator front end.
package calc_pkg;

    localparam logic [6:0] CH_PLUS  = 7'h2B;
    localparam logic [6:0] CH_MINUS = 7'h2D;
    localparam logic [6:0] CH_MUL   = 7'h2A;
    localparam logic [6:0] CH_DIV   = 7'h2F;
    localparam logic [6:0] CH_EQ    = 7'h3D;
    localparam logic [6:0] CH_CLR   = 7'h43;
    localparam logic [6:0] CH_SP    = 7'h20;
    localparam logic [6:0] CH_0     = 7'h30;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EQ   = 3'd3,
        S_EXEC = 3'd4,
        S_OUT  = 3'd5
    } state_t;

endpackage

// File: rtl/calc_char_decode.sv
// Classifies one ASCII character into the token classes the sequencer understands.
module calc_char_decode
    import calc_pkg::*;
(
    input  logic [6:0] in_char,
    output logic       is_digit,
    output logic [1:0] digit,
    output logic       is_op,
    output logic       is_eq,
    output logic       is_clr,
    output logic       is_sp
);

    // '0'..'3' share the upper five bits, so the low two bits are the value.
    assign is_digit = (in_char[6:2] == CH_0[6:2]);
    assign digit    = in_char[1:0];
    assign is_op    = (in_char == CH_PLUS) || (in_char == CH_MINUS) ||
                      (in_char == CH_MUL)  || (in_char == CH_DIV);
    assign is_eq    = (in_char == CH_EQ);
    assign is_clr   = (in_char == CH_CLR);
    assign is_sp    = (in_char == CH_SP);

endmodule

// File: rtl/calc_token_sequencer.sv
// Parses "<digit><op><digit>=" from a byte stream, drives the mini-calculator
// operands from registers and returns its captured result with status flags.
module calc_token_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [6:0] in_char,
    output logic       in_ready,
    output logic [1:0] calc_a,
    output logic [1:0] calc_b,
    output logic [6:0] calc_op,
    input  logic [3:0] calc_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic       out_err,
    output logic       out_div0,
    output logic       out_neg
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

    state_t          state, state_nxt;
    logic [TO_W-1:0] tmo_cnt;
    logic            is_digit, is_op, is_eq, is_clr, is_sp;
    logic [1:0]      digit;
    logic            accept, count_en, timeout_hit, tok_ok, abort, div0;

    calc_char_decode u_decode (
        .in_char  (in_char),
        .is_digit (is_digit),
        .digit    (digit),
        .is_op    (is_op),
        .is_eq    (is_eq),
        .is_clr   (is_clr),
        .is_sp    (is_sp)
    );

    assign accept      = in_valid & in_ready;
    assign count_en    = (state == S_OP) || (state == S_B) || (state == S_EQ);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && count_en && !accept && (tmo_cnt == TO_LAST);
    assign abort       = (accept && !is_sp && !is_clr && !tok_ok) || timeout_hit;
    assign div0        = (calc_op == CH_DIV) && (calc_b == 2'd0);

    // The token class the current state is waiting for.
    always_comb begin
        tok_ok = 1'b0;
        case (state)
            S_A, S_B: tok_ok = is_digit;
            S_OP:     tok_ok = is_op;
            S_EQ:     tok_ok = is_eq;
            default:  tok_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_A;
        else        state <= state_nxt;
    end

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_A, S_OP, S_B, S_EQ: begin
                if (accept && !is_sp) begin
                    if (is_clr)      state_nxt = S_A;
                    else if (!tok_ok) state_nxt = S_OUT;
                    else begin
                        case (state)
                            S_A:     state_nxt = S_OP;
                            S_OP:    state_nxt = S_B;
                            S_B:     state_nxt = S_EQ;
                            default: state_nxt = S_EXEC;
                        endcase
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_OUT;
                end
            end
            S_EXEC:  state_nxt = S_OUT;
            S_OUT:   if (out_ready) state_nxt = S_A;
            default: state_nxt = S_A;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_A) || (state == S_OP) || (state == S_B) || (state == S_EQ);
        out_valid = (state == S_OUT);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_a     <= 2'd0;
            calc_b     <= 2'd0;
            calc_op    <= CH_PLUS;
            tmo_cnt    <= '0;
            out_result <= 4'd0;
            out_err    <= 1'b0;
            out_div0   <= 1'b0;
            out_neg    <= 1'b0;
        end else begin
            if (accept && tok_ok) begin
                case (state)
                    S_A:     calc_a  <= digit;
                    S_OP:    calc_op <= in_char;
                    S_B:     calc_b  <= digit;
                    default: ;
                endcase
            end

            // Spaces neither clear nor advance past the expiry point.
            if (!count_en || (accept && !is_sp)) tmo_cnt <= '0;
            else if (tmo_cnt != TO_LAST)         tmo_cnt <= tmo_cnt + TO_W'(1);

            if (state == S_EXEC) begin
                out_result <= div0 ? 4'd0 : calc_result;
                out_err    <= 1'b0;
                out_div0   <= div0;
                out_neg    <= (calc_op == CH_MINUS) && (calc_a < calc_b);
            end else if (abort) begin
                out_result <= 4'd0;
                out_err    <= 1'b1;
                out_div0   <= 1'b0;
                out_neg    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_token_sequencer.sv
// Randomized scoreboard bench for calc_token_sequencer with a behavioural calculator model.
module tb_calc_token_sequencer;

    localparam logic [6:0] C_PLUS = 7'h2B, C_MINUS = 7'h2D, C_MUL = 7'h2A, C_DIV = 7'h2F;
    localparam logic [6:0] C_EQ = 7'h3D, C_CLR = 7'h43, C_SP = 7'h20, C_X = 7'h78;

    typedef struct packed {
        logic [3:0] res;
        logic       err;
        logic       div0;
        logic       neg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [6:0] in_char, calc_op;
    logic [1:0] calc_a, calc_b;
    logic [3:0] calc_result, out_result;
    logic       out_err, out_div0, out_neg;

    logic       t_in_valid, t_in_ready, t_out_valid;
    logic [6:0] t_in_char, t_calc_op;
    logic [1:0] t_calc_a, t_calc_b;
    logic [3:0] t_calc_result, t_out_result;
    logic       t_out_err, t_out_div0, t_out_neg;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ready_mode = 1;
    exp_t sb_q[$];
    logic [6:0] buf_q[$];

    // Stand-in for the mini-calculator: '/' returns {remainder, quotient}.
    function automatic logic [3:0] calc_fn(input logic [1:0] a, input logic [1:0] b, input logic [6:0] op);
        logic [3:0] r;
        r = 4'd0;
        case (op)
            C_PLUS:  r = {2'b00, a} + {2'b00, b};
            C_MINUS: r = {2'b00, a} - {2'b00, b};
            C_MUL:   r = {2'b00, a} * {2'b00, b};
            C_DIV:   r = (b == 2'd0) ? 4'hF : {a % b, a / b};
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    assign calc_result   = calc_fn(calc_a, calc_b, calc_op);
    assign t_calc_result = calc_fn(t_calc_a, t_calc_b, t_calc_op);

    calc_token_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
        .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op), .calc_result(calc_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_err(out_err), .out_div0(out_div0), .out_neg(out_neg)
    );

    calc_token_sequencer #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut_to (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_char(t_in_char), .in_ready(t_in_ready),
        .calc_a(t_calc_a), .calc_b(t_calc_b), .calc_op(t_calc_op), .calc_result(t_calc_result),
        .out_valid(t_out_valid), .out_ready(1'b1), .out_result(t_out_result),
        .out_err(t_out_err), .out_div0(t_out_div0), .out_neg(t_out_neg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int res, input bit err, input bit dz, input bit ng);
        exp_t e;
        e.res  = 4'(res);
        e.err  = err;
        e.div0 = dz;
        e.neg  = ng;
        return e;
    endfunction

    function automatic bit is_digit_c(input logic [6:0] c);
        return (c >= 7'h30) && (c <= 7'h33);
    endfunction

    function automatic bit is_op_c(input logic [6:0] c);
        return (c == C_PLUS) || (c == C_MINUS) || (c == C_MUL) || (c == C_DIV);
    endfunction

    // Reference: the expression is a 4-token string "d op d =", spaces ignored, 'C' restarts.
    task automatic model_accept(input logic [6:0] c);
        bit ok;
        int a, b, r;
        logic [6:0] op;
        if (c == C_SP) return;
        if (c == C_CLR) begin
            buf_q.delete();
            return;
        end
        case (buf_q.size())
            0, 2:    ok = is_digit_c(c);
            1:       ok = is_op_c(c);
            default: ok = (c == C_EQ);
        endcase
        if (!ok) begin
            sb_q.push_back(mk(0, 1'b1, 1'b0, 1'b0));
            buf_q.delete();
            return;
        end
        buf_q.push_back(c);
        if (buf_q.size() == 4) begin
            a  = int'(buf_q[0]) - 48;
            op = buf_q[1];
            b  = int'(buf_q[2]) - 48;
            r  = 0;
            if (op == C_PLUS)       r = a + b;
            else if (op == C_MINUS) r = (a - b) & 15;
            else if (op == C_MUL)   r = a * b;
            else if (b != 0)        r = (a % b) * 4 + a / b;
            sb_q.push_back(mk(r, 1'b0, (op == C_DIV) && (b == 0), (op == C_MINUS) && (a < b)));
            buf_q.delete();
        end
    endtask

    task automatic send_char(input logic [6:0] c, input int gap);
        int guard;
        guard = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = c;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_wait_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(c);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_expr(input logic [6:0] a, input logic [6:0] op, input logic [6:0] b);
        send_char(a, 0);
        send_char(op, 0);
        send_char(b, 0);
        send_char(C_EQ, 0);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    // Consumer side of the output handshake.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks hold behaviour.
    initial begin
        bit   held, after_hs;
        exp_t held_val, cur;
        held = 1'b0;
        after_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cur = {out_result, out_err, out_div0, out_neg};
                if (after_hs) begin
                    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
                    after_hs = 1'b0;
                end
                if (out_valid) begin
                    check("in_ready_low_while_out_valid", 32'(in_ready), 32'd0);
                    if (held) check("out_held_stable", 32'(cur), 32'(held_val));
                    if (out_ready) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_output", 32'(cur), 32'h7F);
                            n_bad += (cur == 7'h7F) ? 1 : 0;
                        end else begin
                            check("result", 32'(cur), 32'(sb_q.pop_front()));
                        end
                        after_hs = 1'b1;
                        held = 1'b0;
                    end else begin
                        held = 1'b1;
                        held_val = cur;
                    end
                end else begin
                    held = 1'b0;
                end
            end else begin
                held = 1'b0;
                after_hs = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] junk [5];
        logic [6:0] ops [4];
        junk = '{7'h78, 7'h34, 7'h39, 7'h41, 7'h00};
        ops  = '{C_PLUS, C_MINUS, C_MUL, C_DIV};
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_char = 7'h00;
        t_in_valid = 1'b0;
        t_in_char = 7'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({out_valid, in_ready, calc_a, calc_b, calc_op, out_result, out_err, out_div0, out_neg}),
              32'({1'b0, 1'b1, 2'd0, 2'd0, C_PLUS, 4'd0, 1'b0, 1'b0, 1'b0}));
        rst_n = 1'b1;

        // Latency of "3+2=": valid two cycles after '=' is accepted.
        ready_mode = 1;
        send_char(7'h33, 0);
        send_char(C_PLUS, 0);
        send_char(7'h32, 0);
        send_char(C_EQ, 0);
        @(negedge clk);
        check("latency_n_plus_1_low", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_n_plus_2_high", 32'(out_valid), 32'd1);
        wait_drain();

        send_expr(7'h31, C_MINUS, 7'h33);
        send_expr(7'h32, C_DIV, 7'h30);
        send_expr(7'h33, C_DIV, 7'h32);
        send_char(7'h32, 0);
        send_char(C_X, 0);
        send_expr(7'h31, C_MUL, 7'h33);
        send_char(7'h31, 0);
        send_char(C_SP, 1);
        send_char(C_CLR, 0);
        send_expr(7'h32, C_PLUS, 7'h33);
        wait_drain();

        // Consumer stalls for several cycles.
        ready_mode = 2;
        send_expr(7'h32, C_MUL, 7'h33);
        repeat (6) @(negedge clk);
        ready_mode = 1;
        wait_drain();

        // Timeout instance: one digit then silence.
        @(negedge clk);
        t_in_valid = 1'b1;
        t_in_char = 7'h32;
        check("to_in_ready", 32'(t_in_ready), 32'd1);
        @(posedge clk);
        #1 t_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("to_not_yet", 32'(t_out_valid), 32'd0);
        @(negedge clk);
        check("to_fired", 32'({t_out_valid, t_out_result, t_out_err, t_out_div0, t_out_neg}),
              32'({1'b1, 4'd0, 1'b1, 1'b0, 1'b0}));

        // Randomized expressions with spaces, clears, junk and consumer stalls.
        ready_mode = 0;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                logic [6:0] tok;
                if (i == 1)      tok = ops[$urandom_range(0, 3)];
                else if (i == 3) tok = C_EQ;
                else             tok = 7'(7'h30 + $urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0)  send_char(C_SP, $urandom_range(0, 2));
                if ($urandom_range(0, 19) == 0) send_char(junk[$urandom_range(0, 4)], 0);
                if ($urandom_range(0, 24) == 0) send_char(C_CLR, 0);
                send_char(tok, $urandom_range(0, 2));
            end
        end
        ready_mode = 1;
        wait_drain();
        send_char(C_CLR, 0);

        // Reset asserted while waiting for operand b.
        send_char(7'h33, 0);
        send_char(C_MINUS, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        buf_q.delete();
        check("async_reset_outputs", 32'({out_valid, in_ready, calc_a, calc_b, calc_op, out_result, out_err, out_div0, out_neg}),
              32'({1'b0, 1'b1, 2'd0, 2'd0, C_PLUS, 4'd0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        send_expr(7'h33, C_PLUS, 7'h33);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
